// File: rtl/or2_pkg.sv
// Shared constants for the or2 gate and its clocked variants.
// Keeps the reset value of every registered gate output in one place.
package or2_pkg;

    localparam logic RST_BIT = 1'b0;

endpackage

// File: rtl/or2_core.sv
// Pure combinational bitwise OR, shared with the other gate variants.
// No clock or reset, so it works wherever only operands and result are wired.
module or2_core #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    output logic [WIDTH-1:0] z0
);

    assign z0 = x0 | x1;

endmodule

// File: rtl/or2.sv
// Two-input OR gate with an optional registered copy and a per-bit rising-edge pulse.
// z0 depends only on x0/x1, so clk and rst may be left unconnected for plain gate use.
module or2
    import or2_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    output logic [WIDTH-1:0] z0,
    output logic [WIDTH-1:0] z0_q,
    output logic [WIDTH-1:0] z0_rise
);

    localparam logic [WIDTH-1:0] RST_VAL = {WIDTH{RST_BIT}};

    or2_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .x0(x0),
        .x1(x1),
        .z0(z0)
    );

    // Rise compares the incoming result against the value held before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z0_q    <= RST_VAL;
            z0_rise <= RST_VAL;
        end else begin
            z0_q    <= z0;
            z0_rise <= z0 & ~z0_q;
        end
    end

endmodule

// File: tb/tb_or2.sv
// Self-checking bench for or2 at WIDTH=1 and WIDTH=4 sharing one clock and reset.
// Expected values come from a cycle-level model of the OR/latency/edge rules.
module tb_or2;

    logic       clk;
    logic       rst;
    logic       a1, b1;
    logic [3:0] a4, b4;
    logic       z1, q1, r1;
    logic [3:0] z4, q4, r4;

    int checks = 0;
    int errors = 0;

    // model state
    logic       m1_q, m1_rise;
    logic [3:0] m4_q, m4_rise;
    int         rises;

    or2 #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .x0(a1), .x1(b1),
        .z0(z1), .z0_q(q1), .z0_rise(r1)
    );

    or2 #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .x0(a4), .x1(b4),
        .z0(z4), .z0_q(q4), .z0_rise(r4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    // Advance one clock edge, update the model, compare registered outputs.
    task automatic tick();
        logic       i1;
        logic [3:0] i4;
        i1 = a1 | b1;
        i4 = a4 | b4;
        @(posedge clk);
        #1;
        m1_rise = i1 & ~m1_q;
        m1_q    = i1;
        m4_rise = i4 & ~m4_q;
        m4_q    = i4;
        check("q1_model", {3'b0, q1}, {3'b0, m1_q});
        check("rise1_model", {3'b0, r1}, {3'b0, m1_rise});
        check("q4_model", q4, m4_q);
        check("rise4_model", r4, m4_rise);
    endtask

    initial begin
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0;
        a4 = 4'b0; b4 = 4'b0;
        m1_q = 1'b0; m1_rise = 1'b0;
        m4_q = 4'b0; m4_rise = 4'b0;

        // exhaustive 1-bit truth table, 20 ns per vector
        for (int i = 0; i < 4; i++) begin
            a1 = i[1];
            b1 = i[0];
            #10;
            check("truth_table", {3'b0, z1}, {3'b0, (i != 0)});
            #10;
        end

        check("reset_q1", {3'b0, q1}, 4'b0);
        check("reset_rise1", {3'b0, r1}, 4'b0);
        check("reset_q4", q4, 4'b0);
        check("reset_rise4", r4, 4'b0);

        // registered latency and vector mode from reset
        @(negedge clk);
        rst = 1'b0;
        a1 = 1'b1; b1 = 1'b0;
        a4 = 4'b1010; b4 = 4'b0110;
        #1;
        check("vec_comb", z4, 4'b1110);
        tick();
        check("lat_q1", {3'b0, q1}, 4'b0001);
        check("lat_rise1", {3'b0, r1}, 4'b0001);
        check("vec_q4", q4, 4'b1110);
        check("vec_rise4", r4, 4'b1110);
        @(negedge clk);
        tick();
        check("hold_rise1", {3'b0, r1}, 4'b0);
        check("hold_q1", {3'b0, q1}, 4'b0001);

        // async reset between edges
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_q1", {3'b0, q1}, 4'b0);
        check("arst_rise1", {3'b0, r1}, 4'b0);
        check("arst_q4", q4, 4'b0);
        check("arst_z1", {3'b0, z1}, 4'b0001);
        m1_q = 1'b0; m1_rise = 1'b0;
        m4_q = 4'b0; m4_rise = 4'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_q1", {3'b0, q1}, 4'b0001);
        check("post_rst_rise1", {3'b0, r1}, 4'b0001);

        // re-trigger: OR result 0,1,0,1 gives two rise pulses
        rises = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a1 = i[0];
            b1 = 1'b0;
            tick();
            rises += int'(r1);
        end
        check("retrigger_count", 4'(rises), 4'd2);

        // X propagation on the combinational path only; cleared before next edge
        @(negedge clk);
        a1 = 1'b1; b1 = 1'bx;
        #1;
        check("x_one", {3'b0, z1}, 4'b0001);
        a1 = 1'b0;
        #1;
        check("x_zero", {3'b0, z1}, {3'b0, b1});
        b1 = 1'b0;

        // random traffic with occasional mid-cycle resets
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            #1;
            check("rand_z1", {3'b0, z1}, {3'b0, a1 | b1});
            check("rand_z4", z4, a4 | b4);
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
                m1_q = 1'b0; m1_rise = 1'b0;
                m4_q = 4'b0; m4_rise = 4'b0;
                check("rand_rst_q4", q4, 4'b0);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/or2.md
Name: or2

Overview:
- Two-input OR gate primitive for the basic logic-gates library.
- Primary output z0 is purely combinational: z0 = x0 | x1.
- Also provides an optional registered copy of the result and a rising-edge pulse, for use in clocked designs.
- The combinational path must work with clk/rst left unconnected, so the gate can be instantiated with only x0, x1, z0.

Parameters:
- WIDTH, 1, bit width of x0, x1, z0, z0_q; the operation is bitwise OR.

Ports:
- clk     input   1      system clock, rising-edge active; used only by the registered outputs.
- rst     input   1      asynchronous active-high reset; affects only the registered outputs.
- x0      input   WIDTH  operand A.
- x1      input   WIDTH  operand B.
- z0      output  WIDTH  combinational result, x0 | x1.
- z0_q    output  WIDTH  registered result, z0 delayed by one clk cycle.
- z0_rise output  WIDTH  one-cycle pulse per bit when z0_q goes 0->1.

Behaviour:
- z0:
  - Continuous assignment, zero latency, bitwise OR.
  - Truth table per bit: 00->0, 01->1, 10->1, 11->1.
  - Independent of clk and rst; never gated or reset.
  - Must settle within the same simulation timestep as an input change.
- X-propagation on z0 follows standard Verilog | semantics: 1|X = 1, 0|X = X.
- z0_q:
  - On posedge clk, z0_q <= x0 | x1 (one-cycle latency).
  - Reset value is all zeros.
- z0_rise:
  - Registered. On posedge clk, z0_rise <= (x0 | x1) & ~z0_q.
  - Asserts in the same cycle that z0_q first becomes 1, for exactly one cycle, unless that bit of z0_q subsequently returns to 0 and rises again.
  - Reset value is all zeros.
- Reset:
  - Asynchronous assertion: while rst = 1, z0_q and z0_rise are forced to 0 immediately, regardless of clk.
  - After rst deasserts, the first posedge clk loads normally.
  - If a bit's OR result is 1 at that first edge, z0_rise pulses for that bit, because z0_q was 0.
- Reset asserted mid-operation: registered outputs clear at once; z0 keeps tracking its inputs.
- Simultaneous input change and clock edge: the register samples the pre-edge settled value.
- Unconnected clk/rst (floating or X):
  - z0 is unaffected.
  - z0_q and z0_rise are don't-care.
- Widths:
  - All operands are WIDTH bits; no carries.
  - WIDTH >= 1; WIDTH = 1 is the standard gate.

Decomposition:
- No package required. A library-level constant for the reset value (all zeros) may live in the shared gates package if one exists.
- One natural sub-module: or2_core, the pure combinational bitwise OR, reused by other gate variants.
- The register and edge-detect stay in the top module.

Test Plan:
- Exhaustive combinational check, WIDTH = 1, clk/rst unconnected:
  - Apply (x0,x1) = (0,0), (0,1), (1,0), (1,1), 20 ns each.
  - z0 must be 0, 1, 1, 1, valid within each interval.
- Registered latency, WIDTH = 1, rst released:
  - Drive x0 = 1, x1 = 0 before edge N.
  - z0_q = 1 after edge N; z0_rise = 1 for that cycle only; z0_rise = 0 after edge N+1 with inputs held.
- Async reset mid-operation:
  - With z0_q = 1, assert rst between clock edges.
  - z0_q and z0_rise go to 0 immediately, with no clock edge; z0 stays 1.
  - After rst deasserts, z0_q = 1 and z0_rise = 1 at the next edge.
- Re-trigger:
  - Sequence x0|x1 = 1, 0, 1 over consecutive cycles.
  - z0_q follows 1, 0, 1 one cycle late; z0_rise pulses twice.
- Vector mode, WIDTH = 4:
  - x0 = 4'b1010, x1 = 4'b0110 -> z0 = 4'b1110.
  - After an edge from reset: z0_q = 4'b1110, z0_rise = 4'b1110.
- X-propagation, WIDTH = 1:
  - x0 = 1, x1 = X -> z0 = 1.
  - x0 = 0, x1 = X -> z0 = X.
